// File: rtl/frame_buffer_swap_ctrl.sv
// frame_buffer_swap_ctrl
// Multi-buffered frame store controller. One buffer is the display (front)
// buffer, one is the render (back) buffer, the rest sit idle. A renderer
// swap request arms the controller; the next vblank rising edge exchanges
// the roles, optionally followed by a full clear of the new back buffer.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   swap_req, vblank          frame-complete pulse, display blanking level
//   clear_en, clear_color     clear-after-swap enable and fill value
//   disp_addr / disp_data     display read port (1-cycle latency)
//   wr_valid/wr_ready/wr_addr/wr_data   renderer write port
//   front_idx, back_idx       current buffer roles
//   swap_pending, swap_done   armed flag, one-cycle swap pulse
//   ram_wren/ram_addr/ram_data/ram_q    per-buffer RAM ports, slice i = buffer i
module frame_buffer_swap_ctrl #(
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 19,
  parameter int DEPTH   = 307200,
  parameter int NUM_BUF = 2,
  localparam int IDX_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        swap_req,
  input  logic                        vblank,
  input  logic                        clear_en,
  input  logic [DATA_W-1:0]           clear_color,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic [DATA_W-1:0]           disp_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic [IDX_W-1:0]            front_idx,
  output logic [IDX_W-1:0]            back_idx,
  output logic                        swap_pending,
  output logic                        swap_done,
  output logic [NUM_BUF-1:0]          ram_wren,
  output logic [NUM_BUF*ADDR_W-1:0]   ram_addr,
  output logic [NUM_BUF*DATA_W-1:0]   ram_data,
  input  logic [NUM_BUF*DATA_W-1:0]   ram_q
);

  typedef enum logic [1:0] {
    S_WRITE   = 2'd0,
    S_PENDING = 2'd1,
    S_CLEAR   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic                vblank_q;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [IDX_W-1:0]    front_sel_p1;
  logic                vblank_rise;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_BUF - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign vblank_rise = vblank & ~vblank_q;
  assign wr_ready    = (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_WRITE;
      front_idx    <= '0;
      back_idx     <= IDX_W'(1);
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      clr_cnt      <= '0;
      vblank_q     <= 1'b0;
      front_sel_p1 <= '0;
    end else begin
      vblank_q     <= vblank;
      front_sel_p1 <= front_idx;
      swap_done    <= 1'b0;
      case (state)
        S_WRITE: begin
          if (swap_req) begin
            state        <= S_PENDING;
            swap_pending <= 1'b1;
          end
        end
        S_PENDING: begin
          // further swap_req pulses are deliberately not queued
          if (vblank_rise) begin
            front_idx    <= back_idx;
            back_idx     <= next_idx(back_idx);
            swap_done    <= 1'b1;
            swap_pending <= 1'b0;
            clr_cnt      <= '0;
            state        <= clear_en ? S_CLEAR : S_WRITE;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            clr_cnt <= '0;
            state   <= S_WRITE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= S_WRITE;
      endcase
    end
  end

  // RAM port steering: front reads for display, back takes renderer or clear
  // writes, idle buffers are held quiet. Writes are masked while in reset.
  always_comb begin
    ram_wren = '0;
    ram_addr = '0;
    ram_data = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (IDX_W'(i) == front_idx) begin
        ram_addr[i*ADDR_W +: ADDR_W] = disp_addr;
      end else if (IDX_W'(i) == back_idx) begin
        if (state == S_CLEAR) begin
          ram_wren[i]                  = ~rst;
          ram_addr[i*ADDR_W +: ADDR_W] = clr_cnt;
          ram_data[i*DATA_W +: DATA_W] = clear_color;
        end else begin
          ram_wren[i]                  = wr_valid & wr_ready & ~rst;
          ram_addr[i*ADDR_W +: ADDR_W] = wr_addr;
          ram_data[i*DATA_W +: DATA_W] = wr_data;
        end
      end
    end
  end

  // p1: RAM data returns one cycle after the address, so select it with the
  // front index that issued that address.
  always_comb begin
    disp_data = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (front_sel_p1 == IDX_W'(i)) disp_data = ram_q[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_frame_buffer_swap_ctrl.sv
// Testbench for frame_buffer_swap_ctrl: two instances (2 and 3 buffers)
// driven by the same stimulus, each with its own behavioural RAM and model.
module tb_frame_buffer_swap_ctrl;
  localparam int DW  = 9;
  localparam int AW  = 5;
  localparam int DEP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, swap_req, vblank, clear_en, wr_valid;
  logic [DW-1:0] clear_color, wr_data;
  logic [AW-1:0] disp_addr, wr_addr;

  logic [1:0]          rdy_o, pend_o, done_o;
  logic [1:0][DW-1:0]  disp_o;
  logic [1:0][1:0]     front_o, back_o;

  logic [1:0]      wren0;
  logic [2*AW-1:0] addr0;
  logic [2*DW-1:0] wdat0, q0;
  logic [2:0]      wren1;
  logic [3*AW-1:0] addr1;
  logic [3*DW-1:0] wdat1, q1;

  frame_buffer_swap_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_BUF(2)) dut0 (
    .clk(clk), .rst(rst), .swap_req(swap_req), .vblank(vblank),
    .clear_en(clear_en), .clear_color(clear_color),
    .disp_addr(disp_addr), .disp_data(disp_o[0]),
    .wr_valid(wr_valid), .wr_ready(rdy_o[0]), .wr_addr(wr_addr), .wr_data(wr_data),
    .front_idx(front_o[0]), .back_idx(back_o[0]),
    .swap_pending(pend_o[0]), .swap_done(done_o[0]),
    .ram_wren(wren0), .ram_addr(addr0), .ram_data(wdat0), .ram_q(q0)
  );

  frame_buffer_swap_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_BUF(3)) dut1 (
    .clk(clk), .rst(rst), .swap_req(swap_req), .vblank(vblank),
    .clear_en(clear_en), .clear_color(clear_color),
    .disp_addr(disp_addr), .disp_data(disp_o[1]),
    .wr_valid(wr_valid), .wr_ready(rdy_o[1]), .wr_addr(wr_addr), .wr_data(wr_data),
    .front_idx(front_o[1]), .back_idx(back_o[1]),
    .swap_pending(pend_o[1]), .swap_done(done_o[1]),
    .ram_wren(wren1), .ram_addr(addr1), .ram_data(wdat1), .ram_q(q1)
  );

  // uniform views of both instances' RAM ports (instance 0 padded to 3)
  logic [2:0]      w_wren [2];
  logic [3*AW-1:0] w_addr [2];
  logic [3*DW-1:0] w_data [2];
  always_comb begin
    w_wren[0] = {1'b0, wren0};
    w_wren[1] = wren1;
    w_addr[0] = {{AW{1'b0}}, addr0};
    w_addr[1] = addr1;
    w_data[0] = {{DW{1'b0}}, wdat0};
    w_data[1] = wdat1;
  end

  // behavioural RAMs, 1-cycle read latency
  logic [DW-1:0] ram [2][3][32];
  logic [DW-1:0] rq  [2][3];
  logic          ram_init = 1'b0;
  assign q0 = {rq[0][1], rq[0][0]};
  assign q1 = {rq[1][2], rq[1][1], rq[1][0]};

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 3; i++)
          for (int a = 0; a < 32; a++) ram[k][i][a] <= '0;
      ram_init <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 3; i++) begin
          rq[k][i] <= ram[k][i][w_addr[k][i*AW +: AW]];
          if (w_wren[k][i]) ram[k][i][w_addr[k][i*AW +: AW]] <= w_data[k][i*DW +: DW];
        end
    end
  end

  // reference model: roles, phase (0 write, 1 waiting, 2 clearing), memory
  int            m_front [2], m_back [2], m_phase [2], m_cnt [2];
  bit            m_done  [2];
  bit            m_vbq, m_dv, m_init;
  logic [DW-1:0] mm [2][3][32];
  logic [DW-1:0] m_disp [2];

  always @(posedge clk) begin
    if (!m_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 3; i++)
          for (int a = 0; a < 32; a++) mm[k][i][a] = '0;
      m_init = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_front[k] = 0; m_back[k] = 1; m_phase[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end else begin
        m_disp[k] = mm[k][m_front[k]][disp_addr];
        if (m_phase[k] == 0 && wr_valid) mm[k][m_back[k]][wr_addr] = wr_data;
        if (m_phase[k] == 2) mm[k][m_back[k]][m_cnt[k]] = clear_color;
        m_done[k] = 1'b0;
        if (m_phase[k] == 0) begin
          if (swap_req) m_phase[k] = 1;
        end else if (m_phase[k] == 1) begin
          if (vblank && !m_vbq) begin
            m_front[k] = m_back[k];
            m_back[k]  = (m_back[k] + 1) % ((k == 0) ? 2 : 3);
            m_done[k]  = 1'b1;
            m_cnt[k]   = 0;
            m_phase[k] = clear_en ? 2 : 0;
          end
        end else begin
          if (m_cnt[k] == DEP - 1) begin
            m_cnt[k] = 0; m_phase[k] = 0;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
    m_dv  = !rst;
    m_vbq = rst ? 1'b0 : vblank;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < ((k == 0) ? 2 : 3); i++)
          chk($sformatf("wren_in_reset[%0d][%0d]", k, i), 32'(w_wren[k][i]), 0);
      end else begin
        chk($sformatf("wr_ready[%0d]", k), 32'(rdy_o[k]), 32'(m_phase[k] == 0));
        chk($sformatf("front_idx[%0d]", k), 32'(front_o[k]), m_front[k]);
        chk($sformatf("back_idx[%0d]", k), 32'(back_o[k]), m_back[k]);
        chk($sformatf("swap_pending[%0d]", k), 32'(pend_o[k]), 32'(m_phase[k] == 1));
        chk($sformatf("swap_done[%0d]", k), 32'(done_o[k]), 32'(m_done[k]));
        if (m_dv) chk($sformatf("disp_data[%0d]", k), 32'(disp_o[k]), 32'(m_disp[k]));
        for (int i = 0; i < ((k == 0) ? 2 : 3); i++) begin
          if (i == m_front[k]) begin
            chk($sformatf("front_wren[%0d][%0d]", k, i), 32'(w_wren[k][i]), 0);
            chk($sformatf("front_addr[%0d][%0d]", k, i), 32'(w_addr[k][i*AW +: AW]), 32'(disp_addr));
          end else if (i == m_back[k]) begin
            if (m_phase[k] == 0) begin
              chk($sformatf("back_wren[%0d][%0d]", k, i), 32'(w_wren[k][i]), 32'(wr_valid));
              if (wr_valid) begin
                chk($sformatf("back_addr[%0d][%0d]", k, i), 32'(w_addr[k][i*AW +: AW]), 32'(wr_addr));
                chk($sformatf("back_data[%0d][%0d]", k, i), 32'(w_data[k][i*DW +: DW]), 32'(wr_data));
              end
            end else if (m_phase[k] == 1) begin
              chk($sformatf("pend_wren[%0d][%0d]", k, i), 32'(w_wren[k][i]), 0);
            end else begin
              chk($sformatf("clear_wren[%0d][%0d]", k, i), 32'(w_wren[k][i]), 1);
              chk($sformatf("clear_addr[%0d][%0d]", k, i), 32'(w_addr[k][i*AW +: AW]), m_cnt[k]);
              chk($sformatf("clear_data[%0d][%0d]", k, i), 32'(w_data[k][i*DW +: DW]), 32'(clear_color));
            end
          end else begin
            chk($sformatf("idle_wren[%0d][%0d]", k, i), 32'(w_wren[k][i]), 0);
            chk($sformatf("idle_addr[%0d][%0d]", k, i), 32'(w_addr[k][i*AW +: AW]), 0);
            chk($sformatf("idle_data[%0d][%0d]", k, i), 32'(w_data[k][i*DW +: DW]), 0);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic do_swap(input bit clr);
    clear_en = clr;
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    vblank = 1'b1;   tick();
    vblank = 1'b0; clear_en = 1'b0;
    if (clr) repeat (DEP) tick();
    tick();
  endtask

  int pc;
  int ef [4] = '{0, 1, 2, 0};
  int eb [4] = '{1, 2, 0, 1};

  initial begin
    rst = 1'b1; swap_req = 1'b0; vblank = 1'b0; clear_en = 1'b0; wr_valid = 1'b0;
    clear_color = '0; wr_data = '0; disp_addr = '0; wr_addr = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state and first renderer write
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 9'h1AB; disp_addr = 5'd5;
    @(negedge clk);
    chk("rst_front", 32'(front_o[0]), 0);
    chk("rst_back", 32'(back_o[0]), 1);
    chk("rst_ready", 32'(rdy_o[0]), 1);
    chk("wr_wren", 32'(wren0), 32'h2);
    chk("wr_addr_b1", 32'(addr0[AW +: AW]), 5);
    chk("wr_data_b1", 32'(wdat0[DW +: DW]), 32'h1AB);
    chk("disp_addr_b0", 32'(addr0[0 +: AW]), 5);
    tick();
    wr_valid = 1'b0;

    // swap with ten cycles of pending before vblank rises
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    pc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pend_o[0]) pc++;
      tick();
      if (i == 8) vblank = 1'b1;
    end
    @(negedge clk);
    chk("pending_cycles", pc, 10);
    chk("pending_cleared", 32'(pend_o[0]), 0);
    chk("swap_done_pulse", 32'(done_o[0]), 1);
    chk("swap_front", 32'(front_o[0]), 1);
    chk("swap_back", 32'(back_o[0]), 0);
    chk("swap_ready", 32'(rdy_o[0]), 1);
    tick();
    vblank = 1'b0;
    @(negedge clk);
    chk("swap_done_low", 32'(done_o[0]), 0);
    chk("disp_after_swap", 32'(disp_o[0]), 32'h1AB);
    chk("disp_after_swap_nb3", 32'(disp_o[1]), 32'h1AB);
    tick();

    // swap with clear
    clear_color = 9'h000; clear_en = 1'b1;
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    vblank = 1'b1; tick();
    vblank = 1'b0; clear_en = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      chk("clear_ready", 32'(rdy_o[0]), 0);
      chk("clear_wren", 32'(wren0), 32'h2);
      chk("clear_addr", 32'(addr0[AW +: AW]), i);
      tick();
    end
    @(negedge clk);
    chk("clear_end_ready", 32'(rdy_o[0]), 1);
    chk("clear_end_wren", 32'(wren0), 0);
    tick();

    // three swaps on the 3-buffer instance
    do_reset();
    @(negedge clk);
    chk("nb3_front_0", 32'(front_o[1]), ef[0]);
    chk("nb3_back_0", 32'(back_o[1]), eb[0]);
    tick();
    for (int s = 1; s < 4; s++) begin
      do_swap(1'b0);
      @(negedge clk);
      chk($sformatf("nb3_front_%0d", s), 32'(front_o[1]), ef[s]);
      chk($sformatf("nb3_back_%0d", s), 32'(back_o[1]), eb[s]);
      tick();
    end

    // second request while pending is not queued
    do_reset();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; vblank = 1'b1; tick();
    vblank = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("single_swap_front", 32'(front_o[0]), 1);
    chk("no_queued_pending", 32'(pend_o[0]), 0);
    tick();

    // reset in the middle of a clear
    clear_en = 1'b1; clear_color = 9'h155;
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    vblank = 1'b1; tick();
    vblank = 1'b0; clear_en = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wren0", 32'(wren0), 0);
    chk("abort_wren1", 32'(wren1), 0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_front", 32'(front_o[0]), 0);
    chk("abort_back", 32'(back_o[0]), 1);
    chk("abort_ready", 32'(rdy_o[0]), 1);
    chk("abort_no_wren", 32'(wren0), 0);
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 399) == 0);
      swap_req    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 11) == 0) vblank = ~vblank;
      clear_en    = 1'($urandom_range(0, 1));
      clear_color = DW'($urandom);
      wr_valid    = 1'($urandom_range(0, 1));
      wr_addr     = AW'($urandom_range(0, DEP - 1));
      wr_data     = DW'($urandom);
      disp_addr   = AW'($urandom_range(0, DEP - 1));
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
